// File: rtl/restoring_divider_if.sv
// Handshake and operand/result bundle for the shared restoring divider.
// The controller drives the master side; the divider owns the slave side.
interface restoring_divider_if #(
    parameter int W = 8
);
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle.
// Signed operands are divided as magnitudes and the signs are restored at the end.
module restoring_divider #(
    parameter  int W  = 8,
    localparam int CW = $clog2(W + 1)
) (
    input logic             clk,
    input logic             reset,
    restoring_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t state, state_n;

    logic [W:0]    a, a_n;
    logic [W-1:0]  q, q_n;
    logic [W-1:0]  m, m_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sign_q, sign_q_n;
    logic          sign_r, sign_r_n;
    logic          zero, zero_n;
    logic [W-1:0]  raw, raw_n;
    logic [W-1:0]  quo, quo_n;
    logic [W-1:0]  rem, rem_n;
    logic          dbz, dbz_n;
    logic          fin, fin_n;
    logic          done_q;

    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          sd;
    logic          sv;

    assign shifted = {a[W-1:0], q[W-1]};
    assign diff    = shifted - {1'b0, m};

    always_comb begin
        state_n  = state;
        a_n      = a;
        q_n      = q;
        m_n      = m;
        cnt_n    = cnt;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        zero_n   = zero;
        raw_n    = raw;
        quo_n    = quo;
        rem_n    = rem;
        dbz_n    = dbz;
        fin_n    = 1'b0;
        sd       = bus.signed_mode & bus.dividend[W-1];
        sv       = bus.signed_mode & bus.divisor[W-1];

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    q_n      = sd ? -bus.dividend : bus.dividend;
                    m_n      = sv ? -bus.divisor : bus.divisor;
                    sign_q_n = sd ^ sv;
                    sign_r_n = sd;
                    raw_n    = bus.dividend;
                    a_n      = '0;
                    cnt_n    = CW'(W);
                    zero_n   = (bus.divisor == '0);
                    state_n  = zero_n ? FIXUP : CALC;
                end
            end
            CALC: begin
                // Keep the trial subtraction only if it did not borrow.
                if (!diff[W]) begin
                    a_n = diff;
                    q_n = {q[W-2:0], 1'b1};
                end else begin
                    a_n = shifted;
                    q_n = {q[W-2:0], 1'b0};
                end
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = FIXUP;
                end
            end
            FIXUP: begin
                if (zero) begin
                    quo_n = '1;
                    rem_n = raw;
                    dbz_n = 1'b1;
                end else begin
                    quo_n = sign_q ? -q : q;
                    rem_n = sign_r ? -a[W-1:0] : a[W-1:0];
                    dbz_n = 1'b0;
                end
                fin_n   = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a      <= '0;
            q      <= '0;
            m      <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            zero   <= 1'b0;
            raw    <= '0;
            quo    <= '0;
            rem    <= '0;
            dbz    <= 1'b0;
            fin    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            a      <= a_n;
            q      <= q_n;
            m      <= m_n;
            cnt    <= cnt_n;
            sign_q <= sign_q_n;
            sign_r <= sign_r_n;
            zero   <= zero_n;
            raw    <= raw_n;
            quo    <= quo_n;
            rem    <= rem_n;
            dbz    <= dbz_n;
            fin    <= fin_n;
            done_q <= fin;
        end
    end

    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Randomised and directed checks of restoring_divider against an
// integer-arithmetic reference model.
module tb_restoring_divider;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    restoring_divider_if #(.W(W)) bus ();

    restoring_divider #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(
        input  logic         sm,
        input  logic [W-1:0] x,
        input  logic [W-1:0] y,
        output logic [W-1:0] eq,
        output logic [W-1:0] er,
        output logic         ez
    );
        int sx;
        int sy;
        if (y == 0) begin
            eq = '1;
            er = x;
            ez = 1'b1;
        end else if (sm) begin
            sx = $signed(x);
            sy = $signed(y);
            eq = W'(sx / sy);
            er = W'(sx % sy);
            ez = 1'b0;
        end else begin
            eq = x / y;
            er = x % y;
            ez = 1'b0;
        end
    endfunction

    // Issue one operation; lat is edges from accept to done (-1 on timeout).
    task automatic do_op(
        input  logic         sm,
        input  logic [W-1:0] x,
        input  logic [W-1:0] y,
        output int           lat,
        output logic         busy0,
        output logic [W-1:0] q_mid,
        output logic [W-1:0] q,
        output logic [W-1:0] r,
        output logic         z
    );
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.dividend    = x;
        bus.divisor     = y;
        @(posedge clk);
        #1;
        busy0 = bus.busy;
        q_mid = bus.quotient;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        q = 'x;
        r = 'x;
        z = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(posedge clk);
            else if (lat == -1) @(posedge clk);
            #1;
            if (c == 5) q_mid = bus.quotient;
            if (bus.done) begin
                lat = c;
                q = bus.quotient;
                r = bus.remainder;
                z = bus.div_by_zero;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.quotient !== 8'h00 || bus.remainder !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs q=%h r=%h want 00 00",
                     bus.quotient, bus.remainder);
        end
        total++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags busy/done/dbz=%b want 000",
                     {bus.busy, bus.done, bus.div_by_zero});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic         sm_t [7] = '{0, 1, 1, 1, 0, 0, 1};
        logic [W-1:0] x_t  [7] = '{200, 8'h9C, 100, 8'h9C, 8'h55, 9, 8'h80};
        logic [W-1:0] y_t  [7] = '{7, 7, 8'hF9, 8'hF9, 0, 3, 8'hFF};
        logic [W-1:0] q_t  [7] = '{28, 8'hF2, 8'hF2, 8'h0E, 8'hFF, 3, 8'h80};
        logic [W-1:0] r_t  [7] = '{4, 8'hFE, 8'h02, 8'hFE, 8'h55, 0, 8'h00};
        logic         z_t  [7] = '{0, 0, 0, 0, 1, 0, 0};
        int           lat;
        logic         b0;
        logic [W-1:0] qm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           want_lat;
        for (int i = 0; i < 7; i++) begin
            do_op(sm_t[i], x_t[i], y_t[i], lat, b0, qm, q, r, z);
            want_lat = z_t[i] ? 2 : W + 2;
            total++;
            if (b0 !== 1'b1) begin
                bad++;
                $display("FAIL dir%0d_busy got %b want 1", i, b0);
            end
            total++;
            if (lat != want_lat) begin
                bad++;
                $display("FAIL dir%0d_latency got %0d want %0d", i, lat, want_lat);
            end
            total++;
            if (q !== q_t[i] || r !== r_t[i] || z !== z_t[i]) begin
                bad++;
                $display("FAIL dir%0d_result q=%h r=%h z=%b want %h %h %b",
                         i, q, r, z, q_t[i], r_t[i], z_t[i]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_mode = 1'b0;
        bus.dividend = 8'd255;
        bus.divisor = 8'd255;
        @(posedge clk);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = (c == 3);
            if (c == 3) begin
                bus.dividend = 8'd10;
                bus.divisor = 8'd3;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
        total++;
        if (lat != W + 2 || bus.quotient !== 8'd1 || bus.remainder !== 8'd0) begin
            bad++;
            $display("FAIL busy_ignore lat=%0d q=%h r=%h want %0d 01 00",
                     lat, bus.quotient, bus.remainder, W + 2);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        int lat;
        logic b0;
        logic [W-1:0] qm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic z;
        @(negedge clk);
        bus.start = 1'b1;
        bus.signed_mode = 1'b0;
        bus.dividend = 8'd77;
        bus.divisor = 8'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({bus.quotient, bus.remainder} !== 16'h0000 ||
            {bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid q=%h r=%h flags=%b want 00 00 000",
                     bus.quotient, bus.remainder,
                     {bus.busy, bus.done, bus.div_by_zero});
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_no_done got %0d pulses want 0", seen);
        end
        do_op(1'b0, 8'd10, 8'd3, lat, b0, qm, q, r, z);
        total++;
        if (lat != W + 2 || q !== 8'd3 || r !== 8'd1) begin
            bad++;
            $display("FAIL after_reset lat=%0d q=%h r=%h want %0d 03 01",
                     lat, q, r, W + 2);
        end
    endtask

    task automatic test_back_to_back;
        int lat1;
        int lat2;
        logic b0;
        logic [W-1:0] qm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic z;
        do_op(1'b0, 8'd13, 8'd4, lat1, b0, qm, q, r, z);
        total++;
        if (lat1 != W + 2 || q !== 8'd3 || r !== 8'd1) begin
            bad++;
            $display("FAIL b2b_first lat=%0d q=%h r=%h want %0d 03 01",
                     lat1, q, r, W + 2);
        end
        // do_op starts at the next negedge, i.e. inside the done cycle.
        do_op(1'b0, 8'd50, 8'd5, lat2, b0, qm, q, r, z);
        total++;
        if (b0 !== 1'b1 || lat2 != W + 2) begin
            bad++;
            $display("FAIL b2b_accept busy=%b lat=%0d want 1 %0d", b0, lat2, W + 2);
        end
        total++;
        if (qm !== 8'd3) begin
            bad++;
            $display("FAIL b2b_hold mid quotient=%h want 03", qm);
        end
        total++;
        if (q !== 8'd10 || r !== 8'd0) begin
            bad++;
            $display("FAIL b2b_second q=%h r=%h want 0a 00", q, r);
        end
    endtask

    task automatic test_random;
        int lat;
        logic b0;
        logic [W-1:0] qm;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic z;
        logic sm;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic ez;
        int want_lat;
        for (int i = 0; i < 60; i++) begin
            sm = 1'($urandom_range(0, 1));
            x = W'($urandom_range(0, 255));
            y = W'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) y = '0;
            if (i == 7) begin
                sm = 1'b1;
                x = 8'h80;
                y = 8'hFF;
            end
            model(sm, x, y, eq, er, ez);
            do_op(sm, x, y, lat, b0, qm, q, r, z);
            want_lat = ez ? 2 : W + 2;
            total++;
            if (lat != want_lat || q !== eq || r !== er || z !== ez) begin
                bad++;
                $display("FAIL rand%0d sm=%b %h/%h lat=%0d q=%h r=%h z=%b want %0d %h %h %b",
                         i, sm, x, y, lat, q, r, z, want_lat, eq, er, ez);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_directed;
        test_busy_ignore;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
